// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and pipe payload for the RV32I pipeline control unit.
package pipe_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [4:0] ALU_ADD   = 5'd0;
   localparam logic [4:0] ALU_SUB   = 5'd1;
   localparam logic [4:0] ALU_SLL   = 5'd2;
   localparam logic [4:0] ALU_SLT   = 5'd3;
   localparam logic [4:0] ALU_SLTU  = 5'd4;
   localparam logic [4:0] ALU_XOR   = 5'd5;
   localparam logic [4:0] ALU_SRL   = 5'd6;
   localparam logic [4:0] ALU_SRA   = 5'd7;
   localparam logic [4:0] ALU_OR    = 5'd8;
   localparam logic [4:0] ALU_AND   = 5'd9;
   localparam logic [4:0] ALU_PASSB = 5'd10;

   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   localparam logic [1:0] SRCA_RS1  = 2'b00;
   localparam logic [1:0] SRCA_PC   = 2'b01;
   localparam logic [1:0] SRCA_ZERO = 2'b10;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;

   typedef struct packed {
      logic       reg_write;
      logic       mem_write;
      logic       branch;
      logic       jal;
      logic       jalr;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic       alu_src_b;
      logic [4:0] alu_ctrl;
      logic [2:0] funct3;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // alt is funct7[5]; it only matters for funct3 000 (SUB) and 101 (SRA)
   function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op = ALU_SLL;
         3'b010:  alu_op = ALU_SLT;
         3'b011:  alu_op = ALU_SLTU;
         3'b100:  alu_op = ALU_XOR;
         3'b101:  alu_op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op = ALU_OR;
         default: alu_op = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/hazard_unit.sv
// Combinational hazard logic: load-use stall, redirect flush and EX operand forwarding.
module hazard_unit #(
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned FWD_FROM_WB = 1
) (
   input  logic              valid_d_i,
   input  logic [REG_AW-1:0] rs1_d_i,
   input  logic [REG_AW-1:0] rs2_d_i,
   input  logic              use_rs1_d_i,
   input  logic              use_rs2_d_i,
   input  logic [1:0]        result_src_e_i,
   input  logic [REG_AW-1:0] rd_e_i,
   input  logic [REG_AW-1:0] rs1_e_i,
   input  logic [REG_AW-1:0] rs2_e_i,
   input  logic              branch_e_i,
   input  logic              jal_e_i,
   input  logic              jalr_e_i,
   input  logic              btaken_e_i,
   input  logic              reg_write_m_i,
   input  logic [REG_AW-1:0] rd_m_i,
   input  logic              reg_write_w_i,
   input  logic [REG_AW-1:0] rd_w_i,
   output logic              stall_f_o,
   output logic              stall_d_o,
   output logic              flush_d_o,
   output logic              flush_e_o,
   output logic              redirect_e_o,
   output logic [1:0]        fwd_a_e_o,
   output logic [1:0]        fwd_b_e_o
);

   localparam bit WbFwd = (FWD_FROM_WB != 0);

   logic lu;
   logic redirect;
   logic m_hit_a, m_hit_b, w_hit_a, w_hit_b;

   assign lu = valid_d_i && (result_src_e_i == 2'b01) && (rd_e_i != '0) &&
               ((use_rs1_d_i && (rs1_d_i == rd_e_i)) || (use_rs2_d_i && (rs2_d_i == rd_e_i)));

   assign redirect = (branch_e_i & btaken_e_i) | jal_e_i | jalr_e_i;

   // A redirect discards the stalled ID instruction anyway, so it overrides the stall
   assign stall_f_o    = lu & ~redirect;
   assign stall_d_o    = lu & ~redirect;
   assign flush_d_o    = redirect;
   assign flush_e_o    = redirect | lu;
   assign redirect_e_o = redirect;

   assign m_hit_a = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs1_e_i);
   assign m_hit_b = reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs2_e_i);
   assign w_hit_a = WbFwd && reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs1_e_i);
   assign w_hit_b = WbFwd && reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs2_e_i);

   always_comb begin
      fwd_a_e_o = 2'b00;
      fwd_b_e_o = 2'b00;
      if (m_hit_a)      fwd_a_e_o = 2'b10;
      else if (w_hit_a) fwd_a_e_o = 2'b01;
      if (m_hit_b)      fwd_b_e_o = 2'b10;
      else if (w_hit_b) fwd_b_e_o = 2'b01;
   end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// RV32I pipeline control: ID decode, ID/EX, EX/MEM, MEM/WB control pipes and hazard unit.
// Define PIPE_CTRL_MEXT_EN to decode the M extension (MUL..REMU as ALU codes 16..23).
module pipe_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned ALUCTRL_W   = 5,
   parameter int unsigned REG_AW      = 5,
   parameter int unsigned FWD_FROM_WB = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          instr_d,
   input  logic                 valid_d,
   input  logic                 btaken_e,
   output logic                 stall_f,
   output logic                 stall_d,
   output logic                 flush_d,
   output logic                 flush_e,
   output logic [2:0]           imm_src_d,
   output logic                 illegal_d,
   output logic [ALUCTRL_W-1:0] alu_ctrl_e,
   output logic [1:0]           alu_src_a_e,
   output logic                 alu_src_b_e,
   output logic                 branch_e,
   output logic                 jal_e,
   output logic                 jalr_e,
   output logic [REG_AW-1:0]    rs1_e,
   output logic [REG_AW-1:0]    rs2_e,
   output logic [REG_AW-1:0]    rd_e,
   output logic [1:0]           fwd_a_e,
   output logic [1:0]           fwd_b_e,
   output logic                 redirect_e,
   output logic                 mem_write_m,
   output logic [2:0]           funct3_m,
   output logic [REG_AW-1:0]    rd_m,
   output logic                 reg_write_w,
   output logic [1:0]           result_src_w,
   output logic [REG_AW-1:0]    rd_w
);

   logic [6:0] opcode, f7;
   logic [2:0] f3;
   ctrl_t      dec;
   logic       illegal, use_rs1, use_rs2;
   logic [2:0] imm_src;
   ctrl_t      ctrl_e_q, ctrl_e_d, ctrl_m_q, ctrl_w_q;

   assign opcode = instr_d[6:0];
   assign f3     = instr_d[14:12];
   assign f7     = instr_d[31:25];

   always_comb begin
      dec        = CTRL_BUBBLE;
      dec.funct3 = f3;
      dec.rs1    = instr_d[19:15];
      dec.rs2    = instr_d[24:20];
      dec.rd     = instr_d[11:7];
      illegal    = 1'b0;
      use_rs1    = 1'b0;
      use_rs2    = 1'b0;
      imm_src    = IMM_I;
      case (opcode)
         OP_OP: begin
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            dec.reg_write = 1'b1;
            if (f7 == 7'b0000000 || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)))
               dec.alu_ctrl = alu_op(f3, f7[5]);
`ifdef PIPE_CTRL_MEXT_EN
            else if (f7 == 7'b0000001)
               dec.alu_ctrl = {2'b10, f3};
`endif
            else
               illegal = 1'b1;
         end
         OP_IMM: begin
            use_rs1       = 1'b1;
            dec.reg_write = 1'b1;
            dec.alu_src_b = 1'b1;
            // Only shifts constrain the upper bits; elsewhere they are immediate
            if (f3 == 3'b001 && f7 != 7'b0000000) illegal = 1'b1;
            else if (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000) illegal = 1'b1;
            else dec.alu_ctrl = alu_op(f3, (f3 == 3'b101) && f7[5]);
         end
         OP_LOAD: begin
            use_rs1        = 1'b1;
            dec.reg_write  = 1'b1;
            dec.alu_src_b  = 1'b1;
            dec.result_src = RES_MEM;
            illegal        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OP_STORE: begin
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            dec.mem_write = 1'b1;
            dec.alu_src_b = 1'b1;
            imm_src       = IMM_S;
            illegal       = f3[2] || (f3 == 3'b011);
         end
         OP_BRANCH: begin
            use_rs1      = 1'b1;
            use_rs2      = 1'b1;
            dec.branch   = 1'b1;
            dec.alu_ctrl = ALU_SUB;
            imm_src      = IMM_B;
            illegal      = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OP_LUI: begin
            dec.reg_write = 1'b1;
            dec.alu_src_a = SRCA_ZERO;
            dec.alu_src_b = 1'b1;
            dec.alu_ctrl  = ALU_PASSB;
            imm_src       = IMM_U;
         end
         OP_AUIPC: begin
            dec.reg_write = 1'b1;
            dec.alu_src_a = SRCA_PC;
            dec.alu_src_b = 1'b1;
            imm_src       = IMM_U;
         end
         OP_JAL: begin
            dec.reg_write  = 1'b1;
            dec.jal        = 1'b1;
            dec.alu_src_a  = SRCA_PC;
            dec.alu_src_b  = 1'b1;
            dec.result_src = RES_PC4;
            imm_src        = IMM_J;
         end
         OP_JALR: begin
            use_rs1        = 1'b1;
            dec.reg_write  = 1'b1;
            dec.jalr       = 1'b1;
            dec.alu_src_b  = 1'b1;
            dec.result_src = RES_PC4;
            illegal        = (f3 != 3'b000);
         end
         default: illegal = 1'b1;
      endcase
      // Non-writing instructions carry rd=0 so their rd field never looks like a producer
      if (!dec.reg_write) dec.rd = '0;
      if (illegal) begin
         dec     = CTRL_BUBBLE;
         use_rs1 = 1'b0;
         use_rs2 = 1'b0;
         imm_src = IMM_I;
      end
   end

   assign illegal_d = illegal;
   assign imm_src_d = imm_src;
   assign ctrl_e_d  = (flush_e || !valid_d) ? CTRL_BUBBLE : dec;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctrl_e_q <= CTRL_BUBBLE;
         ctrl_m_q <= CTRL_BUBBLE;
         ctrl_w_q <= CTRL_BUBBLE;
      end else begin
         ctrl_e_q <= ctrl_e_d;
         ctrl_m_q <= ctrl_e_q;
         ctrl_w_q <= ctrl_m_q;
      end
   end

   assign alu_ctrl_e   = ALUCTRL_W'(ctrl_e_q.alu_ctrl);
   assign alu_src_a_e  = ctrl_e_q.alu_src_a;
   assign alu_src_b_e  = ctrl_e_q.alu_src_b;
   assign branch_e     = ctrl_e_q.branch;
   assign jal_e        = ctrl_e_q.jal;
   assign jalr_e       = ctrl_e_q.jalr;
   assign rs1_e        = REG_AW'(ctrl_e_q.rs1);
   assign rs2_e        = REG_AW'(ctrl_e_q.rs2);
   assign rd_e         = REG_AW'(ctrl_e_q.rd);
   assign mem_write_m  = ctrl_m_q.mem_write;
   assign funct3_m     = ctrl_m_q.funct3;
   assign rd_m         = REG_AW'(ctrl_m_q.rd);
   assign reg_write_w  = ctrl_w_q.reg_write;
   assign result_src_w = ctrl_w_q.result_src;
   assign rd_w         = REG_AW'(ctrl_w_q.rd);

   logic unused_w;
   assign unused_w = ^ctrl_w_q;

   hazard_unit #(
      .REG_AW      (REG_AW),
      .FWD_FROM_WB (FWD_FROM_WB)
   ) u_hazard (
      .valid_d_i      (valid_d),
      .rs1_d_i        (REG_AW'(instr_d[19:15])),
      .rs2_d_i        (REG_AW'(instr_d[24:20])),
      .use_rs1_d_i    (use_rs1),
      .use_rs2_d_i    (use_rs2),
      .result_src_e_i (ctrl_e_q.result_src),
      .rd_e_i         (rd_e),
      .rs1_e_i        (rs1_e),
      .rs2_e_i        (rs2_e),
      .branch_e_i     (ctrl_e_q.branch),
      .jal_e_i        (ctrl_e_q.jal),
      .jalr_e_i       (ctrl_e_q.jalr),
      .btaken_e_i     (btaken_e),
      .reg_write_m_i  (ctrl_m_q.reg_write),
      .rd_m_i         (rd_m),
      .reg_write_w_i  (ctrl_w_q.reg_write),
      .rd_w_i         (rd_w),
      .stall_f_o      (stall_f),
      .stall_d_o      (stall_d),
      .flush_d_o      (flush_d),
      .flush_e_o      (flush_e),
      .redirect_e_o   (redirect_e),
      .fwd_a_e_o      (fwd_a_e),
      .fwd_b_e_o      (fwd_b_e)
   );

endmodule
